// File: rtl/t5_wbarb_if.sv
// ---------------------------------------------------------------------------
// t5_wbarb_if
// Wishbone-style bus bundle for the t5_rv32i fetch, data and memory buses.
//   adr  [31:2]  word address              (master -> slave)
//   dto  XLEN    write data                (master -> slave)
//   sel  4       byte selects              (master -> slave)
//   stb  1       request, held until ack   (master -> slave)
//   wre  1       1 = write, 0 = read       (master -> slave)
//   ack  1       transfer acknowledge      (slave -> master)
//   dti  XLEN    read data                 (slave -> master)
// ---------------------------------------------------------------------------
interface t5_wbarb_if #(
    parameter int XLEN = 32
);
    logic [31:2]     adr;
    logic [XLEN-1:0] dto;
    logic [XLEN-1:0] dti;
    logic [3:0]      sel;
    logic            stb;
    logic            wre;
    logic            ack;

    modport master (output adr, dto, sel, stb, wre, input ack, dti);
    modport slave  (input adr, dto, sel, stb, wre, output ack, dti);
endinterface

// File: rtl/t5_wbarb.sv
// ---------------------------------------------------------------------------
// t5_wbarb
// Round-robin arbiter merging the instruction-fetch bus and the data bus of
// t5_rv32i onto one shared memory bus, with a per-transfer watchdog.
//   sys_clk  in   clock, rising edge
//   sys_rst  in   asynchronous active-high reset
//   iwb      slave  fetch bus (wre and dto are ignored: fetch always reads)
//   dwb      slave  data bus
//   mwb      master shared memory bus
//   bus_err  out  one-cycle pulse when the watchdog terminates a transfer
// The watchdog fires in the 2^TMOW-th granted cycle without mwb ack.
// ---------------------------------------------------------------------------
module t5_wbarb #(
    parameter int XLEN = 32,
    parameter int TMOW = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    t5_wbarb_if.slave   iwb,
    t5_wbarb_if.slave   dwb,
    t5_wbarb_if.master  mwb,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    localparam logic [TMOW-1:0] TMO_ONE = TMOW'(1);

    state_t          state_reg, state_next;
    logic            last_d_reg, last_d_next;   // 1 = data master was granted last
    logic [TMOW-1:0] tmo_reg, tmo_next;
    logic            timeout;
    logic            xfer_done;

    // Fetch bus never writes; its write-side signals are deliberately dropped.
    logic unused_bits;
    assign unused_bits = ^{iwb.wre, iwb.dto};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg  <= IDLE;
            last_d_reg <= 1'b0;
            tmo_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            last_d_reg <= last_d_next;
            tmo_reg    <= tmo_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        last_d_next = last_d_reg;
        tmo_next    = '0;
        mwb.adr     = '0;
        mwb.sel     = '0;
        mwb.stb     = 1'b0;
        mwb.wre     = 1'b0;
        mwb.dto     = '0;
        iwb.ack     = 1'b0;
        dwb.ack     = 1'b0;
        bus_err     = 1'b0;

        // A real ack in the last watchdog cycle takes precedence over timeout.
        timeout   = (state_reg != IDLE) && (tmo_reg == '1) && !mwb.ack;
        xfer_done = mwb.ack || timeout;

        // Read data is broadcast; it is zeroed only for a forced (timeout) ack.
        iwb.dti = timeout ? '0 : mwb.dti;
        dwb.dti = timeout ? '0 : mwb.dti;

        case (state_reg)
            IDLE: begin
                if (iwb.stb && dwb.stb) begin
                    state_next = last_d_reg ? GNT_I : GNT_D;
                end else if (iwb.stb) begin
                    state_next = GNT_I;
                end else if (dwb.stb) begin
                    state_next = GNT_D;
                end
            end
            GNT_I: begin
                mwb.adr = iwb.adr;
                mwb.sel = iwb.sel;
                mwb.stb = iwb.stb;
                iwb.ack = xfer_done;
                bus_err = timeout;
                if (xfer_done) begin
                    last_d_next = 1'b0;
                    state_next  = dwb.stb ? GNT_D : IDLE;
                end else begin
                    tmo_next = tmo_reg + TMO_ONE;
                end
            end
            GNT_D: begin
                mwb.adr = dwb.adr;
                mwb.sel = dwb.sel;
                mwb.stb = dwb.stb;
                mwb.wre = dwb.wre;
                mwb.dto = dwb.dto;
                dwb.ack = xfer_done;
                bus_err = timeout;
                if (xfer_done) begin
                    last_d_next = 1'b1;
                    state_next  = iwb.stb ? GNT_I : IDLE;
                end else begin
                    tmo_next = tmo_reg + TMO_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
